// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_rr_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // One latched downstream request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // Index width for n requesters, never below 1 bit
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set req bit at or after start, wrapping.
module mem_rr_arbiter_rr_pick
  import mem_rr_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Rotate requests so start lands on bit 0, then take the lowest set bit
  always_comb begin
    req_dbl = {req, req};
    req_rot = N'(req_dbl >> start);
    any     = |req;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) idx = IDX_W'((32'(start) + 32'(i)) % N);
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter: N picorv32 native memory ports onto one shared memory/IO port.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter  int unsigned N_CORES = 2,
  localparam int unsigned IDX_W   = idx_width(N_CORES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CORES-1:0]      core_valid,
  input  logic [32*N_CORES-1:0]   core_addr,
  input  logic [32*N_CORES-1:0]   core_wdata,
  input  logic [4*N_CORES-1:0]    core_wstrb,
  output logic [N_CORES-1:0]      core_ready,
  output logic [32*N_CORES-1:0]   core_rdata,
  output logic                    mem_valid,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wstrb,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata,
  output logic [IDX_W-1:0]        grant_idx
);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  mem_req_t         req_q;
  mem_req_t         pick_req_c;
  logic             pick_any_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic [IDX_W-1:0] rr_next_c;

  mem_rr_arbiter_rr_pick #(.N(N_CORES)) u_pick (
    .req   (core_valid),
    .start (rr_ptr),
    .any   (pick_any_c),
    .idx   (pick_idx_c)
  );

  // Select the picked core's request fields
  always_comb begin
    pick_req_c = '0;
    for (int k = 0; k < int'(N_CORES); k++) begin
      if (pick_idx_c == IDX_W'(k)) begin
        pick_req_c.addr  = core_addr[32*k +: 32];
        pick_req_c.wdata = core_wdata[32*k +: 32];
        pick_req_c.wstrb = core_wstrb[4*k +: 4];
      end
    end
  end

  // Priority moves to the core after the one just served
  always_comb begin
    rr_next_c = IDX_W'((32'(grant_idx) + 32'd1) % N_CORES);
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

  // Arbitration FSM with registered request, response and grant state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      req_q      <= '0;
      mem_valid  <= 1'b0;
      core_ready <= '0;
      core_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any_c) begin
            req_q     <= pick_req_c;
            grant_idx <= pick_idx_c;
            mem_valid <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            core_ready <= N_CORES'(1) << grant_idx;
            for (int k = 0; k < int'(N_CORES); k++) begin
              if (grant_idx == IDX_W'(k) && req_q.wstrb == '0)
                core_rdata[32*k +: 32] <= mem_rdata;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Served core sees ready here and drops valid before the next scan
          core_ready <= '0;
          rr_ptr     <= rr_next_c;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter with a transaction-level round-robin model.
module tb_mem_rr_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned IW = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    core_valid;
  logic [32*N-1:0] core_addr;
  logic [32*N-1:0] core_wdata;
  logic [4*N-1:0]  core_wstrb;
  logic [N-1:0]    core_ready;
  logic [32*N-1:0] core_rdata;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [IW-1:0]   grant_idx;

  mem_rr_arbiter #(.N_CORES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_valid (core_valid),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wstrb (core_wstrb),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Core-side request state: pend[k] holds core_valid until core k sees ready
  logic [N-1:0] pend;
  logic [31:0]  r_addr  [N];
  logic [31:0]  r_wdata [N];
  logic [3:0]   r_wstrb [N];

  // Memory-side model state
  int          mem_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] next_rdata;
  bit          stray_en   = 1'b0;
  bit          resp_given = 1'b0;
  logic [31:0] resp_data;

  task automatic apply();
    core_valid = pend;
    for (int k = 0; k < int'(N); k++) begin
      core_addr[32*k +: 32]  = r_addr[k];
      core_wdata[32*k +: 32] = r_wdata[k];
      core_wstrb[4*k +: 4]   = r_wstrb[k];
    end
  endtask

  // One clock: memory responds after mem_delay cycles, cores drop valid on ready
  task automatic tick();
    @(posedge clk);
    #1;
    resp_given = 1'b0;
    mem_ready  = 1'b0;
    if (mem_valid) begin
      if (wait_cnt == 0) begin
        mem_ready  = 1'b1;
        mem_rdata  = next_rdata;
        resp_given = 1'b1;
        resp_data  = next_rdata;
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = mem_delay;
      if (stray_en) begin
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
      end
    end
    for (int k = 0; k < int'(N); k++) if (core_ready[k]) pend[k] = 1'b0;
    apply();
  endtask

  task automatic do_reset(input logic [N-1:0] p);
    reset = 1'b1;
    pend  = p;
    apply();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pend != '0 || mem_valid || core_ready != '0) && n < 60) begin
      tick();
      n++;
    end
    compared++;
    if (n >= 60) begin
      mismatched++;
      $display("FAIL %s_drain: still busy after %0d cycles pend=%b mem_valid=%b", name, n, pend, mem_valid);
    end
  endtask

  task automatic test_reset();
    do_reset('0);
    compared++;
    if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, core_ready, core_rdata, grant_idx} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: got mv=%b a=%h wd=%h ws=%h rdy=%b rd=%h g=%0d expected all zero",
               mem_valid, mem_addr, mem_wdata, mem_wstrb, core_ready, core_rdata, grant_idx);
    end
    stray_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, core_ready, core_rdata, grant_idx} !== '0) begin
        mismatched++;
        $display("FAIL idle_%0d: got mv=%b rdy=%b rd=%h g=%0d expected all zero",
                 i, mem_valid, core_ready, core_rdata, grant_idx);
      end
    end
    stray_en  = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_single_read();
    r_addr[1] = 32'h0000_0040; r_wdata[1] = $urandom; r_wstrb[1] = 4'd0;
    next_rdata = 32'hDEAD_BEEF;
    pend[1] = 1'b1;
    apply();
    tick();
    compared++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mem_wstrb !== 4'd0 || grant_idx !== 1'b1 || core_ready !== 2'b00) begin
      mismatched++;
      $display("FAIL read_issue: got mv=%b a=%h ws=%h g=%0d rdy=%b expected mv=1 a=00000040 ws=0 g=1 rdy=00",
               mem_valid, mem_addr, mem_wstrb, grant_idx, core_ready);
    end
    tick();
    compared++;
    if (core_ready !== 2'b10 || core_rdata[63:32] !== 32'hDEAD_BEEF || mem_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL read_resp: got rdy=%b rd1=%h mv=%b expected rdy=10 rd1=deadbeef mv=0",
               core_ready, core_rdata[63:32], mem_valid);
    end
    tick();
    compared++;
    if (core_ready !== 2'b00) begin
      mismatched++;
      $display("FAIL read_pulse_width: got rdy=%b expected 00", core_ready);
    end
    drain("read");
  endtask

  task automatic test_contention();
    int          np;
    int          p_cyc [8];
    logic [N-1:0] p_val [8];
    logic [IW-1:0] p_gnt [8];
    logic [N-1:0] exp_v;
    np = 0;
    for (int k = 0; k < int'(N); k++) begin
      r_addr[k] = $urandom & 32'hFFFF_FFFC; r_wdata[k] = $urandom; r_wstrb[k] = 4'd0;
    end
    next_rdata = $urandom;
    do_reset(2'b11);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < int'(N); k++) if (!pend[k] && !core_ready[k]) pend[k] = 1'b1;
      apply();
      tick();
      if (core_ready != '0 && np < 8) begin
        p_cyc[np] = i; p_val[np] = core_ready; p_gnt[np] = grant_idx; np++;
      end
    end
    compared++;
    if (np != 4) begin
      mismatched++;
      $display("FAIL contention_count: got %0d ready pulses expected 4", np);
    end
    if (np > 0) begin
      compared++;
      if (p_cyc[0] != 1) begin
        mismatched++;
        $display("FAIL contention_latency: first ready at cycle %0d expected 1", p_cyc[0]);
      end
    end
    for (int j = 0; j < np; j++) begin
      exp_v = (j % 2 == 0) ? 2'b01 : 2'b10;
      compared++;
      if (p_val[j] !== exp_v || p_gnt[j] !== IW'(j % 2)) begin
        mismatched++;
        $display("FAIL contention_grant_%0d: got rdy=%b g=%0d expected rdy=%b g=%0d", j, p_val[j], p_gnt[j], exp_v, j % 2);
      end
      if (j > 0) begin
        compared++;
        if (p_cyc[j] - p_cyc[j-1] != 3) begin
          mismatched++;
          $display("FAIL contention_spacing_%0d: got %0d cycles expected 3", j, p_cyc[j] - p_cyc[j-1]);
        end
      end
    end
    pend = '0;
    apply();
    drain("contention");
  endtask

  task automatic test_write();
    r_addr[0] = 32'h0000_2000; r_wdata[0] = 32'h0; r_wstrb[0] = 4'd0;
    next_rdata = 32'hCAFE_F00D;
    pend[0] = 1'b1;
    apply();
    drain("write_pre");
    compared++;
    if (core_rdata[31:0] !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("FAIL write_preload: got rd0=%h expected cafef00d", core_rdata[31:0]);
    end
    r_addr[0] = 32'h1000_0000; r_wdata[0] = 32'h0000_00A5; r_wstrb[0] = 4'b0001;
    next_rdata = 32'h1234_5678;
    pend[0] = 1'b1;
    apply();
    tick();
    compared++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h1000_0000 || mem_wdata !== 32'hA5 || mem_wstrb !== 4'b0001 || grant_idx !== 1'b0) begin
      mismatched++;
      $display("FAIL write_forward: got mv=%b a=%h wd=%h ws=%b g=%0d expected mv=1 a=10000000 wd=000000a5 ws=0001 g=0",
               mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_idx);
    end
    tick();
    compared++;
    if (core_ready !== 2'b01 || core_rdata[31:0] !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("FAIL write_resp: got rdy=%b rd0=%h expected rdy=01 rd0=cafef00d", core_ready, core_rdata[31:0]);
    end
    drain("write");
  endtask

  task automatic test_slow_mem();
    int n_high;
    mem_delay = 5;
    tick();
    r_addr[1] = 32'h0000_0044; r_wdata[1] = $urandom; r_wstrb[1] = 4'b1100;
    next_rdata = $urandom;
    pend[1] = 1'b1;
    apply();
    tick();
    compared++;
    if (mem_valid !== 1'b1 || grant_idx !== 1'b1) begin
      mismatched++;
      $display("FAIL slow_issue: got mv=%b g=%0d expected mv=1 g=1", mem_valid, grant_idx);
    end
    r_addr[0] = 32'h0000_0080; r_wdata[0] = $urandom; r_wstrb[0] = 4'd0;
    pend[0] = 1'b1;
    apply();
    n_high = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!mem_valid) break;
      n_high++;
      compared++;
      if (mem_addr !== r_addr[1] || mem_wdata !== r_wdata[1] || mem_wstrb !== r_wstrb[1] || grant_idx !== 1'b1) begin
        mismatched++;
        $display("FAIL slow_stable_%0d: got a=%h wd=%h ws=%b g=%0d expected a=%h wd=%h ws=%b g=1",
                 i, mem_addr, mem_wdata, mem_wstrb, grant_idx, r_addr[1], r_wdata[1], r_wstrb[1]);
      end
    end
    compared++;
    if (n_high != 6 || core_ready !== 2'b10) begin
      mismatched++;
      $display("FAIL slow_length: got %0d cycles rdy=%b expected 6 cycles rdy=10", n_high, core_ready);
    end
    tick();
    compared++;
    if (mem_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL slow_no_early_grant: got mv=%b expected 0 during RESP", mem_valid);
    end
    tick();
    compared++;
    if (mem_valid !== 1'b1 || grant_idx !== 1'b0 || mem_addr !== 32'h80) begin
      mismatched++;
      $display("FAIL slow_next_grant: got mv=%b g=%0d a=%h expected mv=1 g=0 a=00000080", mem_valid, grant_idx, mem_addr);
    end
    mem_delay = 0;
    drain("slow");
  endtask

  task automatic test_reset_mid_req();
    mem_delay = 10;
    tick();
    r_addr[1] = 32'h0000_0100; r_wdata[1] = $urandom; r_wstrb[1] = 4'd0;
    pend[1] = 1'b1;
    apply();
    tick();
    compared++;
    if (mem_valid !== 1'b1 || grant_idx !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_issue: got mv=%b g=%0d expected mv=1 g=1", mem_valid, grant_idx);
    end
    tick();
    tick();
    mem_delay = 0;
    reset = 1'b1;
    tick();
    compared++;
    if (mem_valid !== 1'b0 || core_ready !== 2'b00 || grant_idx !== 1'b0 || mem_addr !== 32'h0 || core_rdata !== '0) begin
      mismatched++;
      $display("FAIL abort_values: got mv=%b rdy=%b g=%0d a=%h rd=%h expected all zero",
               mem_valid, core_ready, grant_idx, mem_addr, core_rdata);
    end
    for (int k = 0; k < int'(N); k++) begin
      r_addr[k] = $urandom & 32'hFFFF_FFFC; r_wdata[k] = $urandom; r_wstrb[k] = 4'd0;
    end
    pend = 2'b11;
    reset = 1'b0;
    apply();
    tick();
    compared++;
    if (mem_valid !== 1'b1 || grant_idx !== 1'b0 || mem_addr !== r_addr[0]) begin
      mismatched++;
      $display("FAIL abort_regrant: got mv=%b g=%0d a=%h expected mv=1 g=0 a=%h", mem_valid, grant_idx, mem_addr, r_addr[0]);
    end
    drain("abort");
  endtask

  task automatic test_random();
    int           model_ptr, model_out, starve, exp_c;
    int           served [N];
    logic [63:0]  exp_rdata;
    logic [31:0]  o_addr, o_wdata, rd;
    logic [3:0]   o_wstrb;
    logic [N-1:0] pend_prev, exp_ready;
    bit           due, prev_mv;
    model_ptr = 0; model_out = -1; starve = 0; exp_rdata = '0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0;
    for (int k = 0; k < int'(N); k++) served[k] = 0;
    do_reset('0);
    stray_en = 1'b1;
    for (int it = 0; it < 800; it++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (!pend[k] && !core_ready[k] && $urandom_range(0, 2) == 0) begin
          pend[k]    = 1'b1;
          r_addr[k]  = $urandom & 32'hFFFF_FFFC;
          r_wdata[k] = $urandom;
          r_wstrb[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        end
      end
      mem_delay  = int'($urandom_range(0, 3));
      next_rdata = $urandom;
      apply();
      pend_prev = pend;
      due       = resp_given;
      rd        = resp_data;
      prev_mv   = mem_valid;
      tick();
      // Completion: ready goes only to the owner, exactly once
      compared++;
      exp_ready = (due && model_out >= 0) ? (N'(1) << model_out) : '0;
      if (core_ready !== exp_ready || (due && mem_valid !== 1'b0)) begin
        mismatched++;
        $display("FAIL rand_ready_%0d: got rdy=%b mv=%b expected rdy=%b", it, core_ready, mem_valid, exp_ready);
      end
      if (due && model_out >= 0) begin
        if (o_wstrb == 4'd0) exp_rdata[32*model_out +: 32] = rd;
        served[model_out]++;
        model_ptr = (model_out + 1) % int'(N);
        model_out = -1;
      end
      // New grant: first pending core at or after the rotating pointer
      if (mem_valid && !prev_mv) begin
        exp_c = -1;
        for (int off = 0; off < int'(N); off++) begin
          if (exp_c < 0 && pend_prev[(model_ptr + off) % int'(N)]) exp_c = (model_ptr + off) % int'(N);
        end
        compared++;
        if (model_out >= 0 || exp_c < 0) begin
          mismatched++;
          $display("FAIL rand_grant_%0d: got grant while outstanding=%0d expected_core=%0d", it, model_out, exp_c);
        end else if (grant_idx !== IW'(exp_c) || mem_addr !== r_addr[exp_c] || mem_wdata !== r_wdata[exp_c] || mem_wstrb !== r_wstrb[exp_c]) begin
          mismatched++;
          $display("FAIL rand_grant_%0d: got g=%0d a=%h wd=%h ws=%b expected g=%0d a=%h wd=%h ws=%b",
                   it, grant_idx, mem_addr, mem_wdata, mem_wstrb, exp_c, r_addr[exp_c], r_wdata[exp_c], r_wstrb[exp_c]);
        end
        if (exp_c >= 0) begin
          model_out = exp_c;
          o_addr = r_addr[exp_c]; o_wdata = r_wdata[exp_c]; o_wstrb = r_wstrb[exp_c];
        end
      end else if (mem_valid && prev_mv) begin
        compared++;
        if (model_out < 0 || grant_idx !== IW'(model_out) || mem_addr !== o_addr || mem_wdata !== o_wdata || mem_wstrb !== o_wstrb) begin
          mismatched++;
          $display("FAIL rand_hold_%0d: got g=%0d a=%h wd=%h ws=%b expected g=%0d a=%h wd=%h ws=%b",
                   it, grant_idx, mem_addr, mem_wdata, mem_wstrb, model_out, o_addr, o_wdata, o_wstrb);
        end
      end
      compared++;
      if (core_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL rand_rdata_%0d: got %h expected %h", it, core_rdata, exp_rdata);
      end
      if (model_out < 0 && pend != '0) starve++;
      else starve = 0;
      if (starve > 3) begin
        compared++;
        mismatched++;
        $display("FAIL rand_starve_%0d: pending %b not granted for %0d cycles", it, pend, starve);
        break;
      end
    end
    compared++;
    if (served[0] == 0 || served[1] == 0) begin
      mismatched++;
      $display("FAIL rand_coverage: got served0=%0d served1=%0d expected both nonzero", served[0], served[1]);
    end
    stray_en  = 1'b0;
    mem_delay = 0;
    drain("random");
  endtask

  initial begin
    reset      = 1'b1;
    pend       = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    next_rdata = '0;
    resp_data  = '0;
    for (int k = 0; k < int'(N); k++) begin
      r_addr[k] = '0; r_wdata[k] = '0; r_wstrb[k] = '0;
    end
    apply();
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_slow_mem();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
